z80_bus_master: RTL and testbench
=================================

# z80_bus_master

Z80-compatible bus initiator. It turns single-beat commands from on-chip logic (diagnostic sequencer, loader) into Z80-style memory and I/O read/write cycles (T1/T2/TW/T3) on the shared address/data bus. It is the initiating end of the bus that the ROM/RAM responders serve: it drives address, MREQ/IOREQ/RD/WR and write data, honours WAIT, and captures read data.

## Interface
- TDIV, 4: clk cycles per T-state; legal range 2..255.
- WAIT_MAX, 255: maximum wait T-states before abort; used only when the timeout feature is compiled in.

- clk  in  1  system clock (internal oscillator domain).
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_io  in  1  1 = I/O cycle (IOREQ), 0 = memory cycle (MREQ).
- cmd_addr  in  16  target address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: cycle complete.
- rsp_rdata  out  8  captured read data; holds its value until the next read completes.
- rsp_err  out  1  qualified by rsp_valid; 1 = cycle aborted by timeout.
- address  out  16  bus address.
- data_out  out  8  bus write data.
- data_oe  out  1  data pad output enable.
- data_in  in  8  bus read data from pads.
- mreq_n, ioreq_n, rd_n, wr_n, m1_n  out  1 each  active-low bus strobes. m1_n is always 1.
- wait_n  in  1  asynchronous bus wait request.

## Operation
- States: IDLE, T1, T2, TW, T3. Every non-IDLE state lasts exactly TDIV clks, counted by an 8-bit tcount.
- cmd_ready = 1 only in IDLE with rst_n high. A command is accepted on an edge where cmd_valid & cmd_ready. On acceptance, cmd_addr, cmd_wdata, cmd_we and cmd_io are latched, and the next state is T1.
- T1: address is driven with the latched address. For a write, data_out is driven and data_oe = 1 from T1 onward. All strobes stay high.
- T2 and TW: the selected request strobe (mreq_n for memory, ioreq_n for I/O) is low, and either rd_n or wr_n is low.
- wait_n passes through a 2-flop synchronizer. On the last clk of T2 or TW:
  - synchronized wait_n = 0 → TW.
  - otherwise → T3.
- I/O cycles always insert exactly one TW after T2, before wait_n is evaluated; wait_n is then sampled at the end of that TW.
- T3: strobes stay asserted. On the last clk of T3, a read registers data_in into rsp_rdata.
- Leaving T3 goes to IDLE. In that same edge: all strobes go high, data_oe goes to 0, and rsp_valid pulses for 1 clk.
- address and data_out keep their last values in IDLE.

## Timing
- Reset values: address 0, data_out 0, data_oe 0, all *_n 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, state IDLE, synchronizer flops 1.
- rst_n low in any state forces the reset values at the next edge. The command is dropped and no rsp_valid is produced.
- Latency from the accept edge to rsp_valid high:
  - memory cycle, no waits: 3·TDIV+1 clks (13 at TDIV=4).
  - each wait T-state adds TDIV.
  - I/O cycle, no extra waits: 4·TDIV+1 clks.
- A new command may be accepted in the same cycle rsp_valid is high (IDLE). Back-to-back cycles therefore give one IDLE clk between T3 and T1.
- The wait_n sync delay is 2 clks. wait_n must be low at least 2 clks before the end of T2 to be honoured.
- Command inputs are ignored outside the accept edge; changes mid-cycle have no effect.

## Configuration
- Macro: Z80_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - a wait counter counts TW states, excluding the I/O mandatory TW.
  - when the count reaches WAIT_MAX while wait_n is still low, the next state is T3 regardless of wait_n.
  - the response carries rsp_err = 1, and rsp_rdata is not updated on aborted reads.
  - the counter clears in IDLE.
- Undefined:
  - no counter; TW repeats indefinitely while wait_n = 0.
  - rsp_err is constant 0.

## Test plan
- Reset / idle: hold rst_n low 3 clks → all reset values, cmd_ready 0; release → cmd_ready 1 next clk.
- Memory read, TDIV=4: addr 0x0100, data_in=0xA5, wait_n=1 → mreq_n and rd_n low for exactly 8 clks, rsp_valid at accept+13, rsp_rdata=0xA5, rsp_err=0.
- Memory write: addr 0x9FFF, data 0x3C → data_oe high 12 clks, wr_n low 8 clks, rd_n stays 1, rsp_valid at accept+13.
- Wait states: memory read with wait_n low for 10 clks starting at T1 → exactly 2 TW inserted, rsp_valid at accept+21.
- I/O read: port 0x00FE, wait_n=1 → ioreq_n low, mreq_n stays 1, one TW, rsp_valid at accept+17; reset pulsed during TW → strobes high next edge, no rsp_valid.
- Timeout (macro defined, WAIT_MAX=3): wait_n held low → 3 TW then T3, rsp_valid with rsp_err=1, rsp_rdata unchanged; macro undefined → no rsp_valid after 1000 clks.

Source files
------------

// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: turns single-beat commands into T1/T2/TW/T3 memory and I/O cycles.
// Define Z80_BUS_MASTER_TIMEOUT_EN to abort cycles after WAIT_MAX wait states (rsp_err = 1).
module z80_bus_master #(
    parameter int TDIV     = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_io,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] address,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_n,
    output logic        ioreq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m1_n,
    input  logic        wait_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4
    } state_e;

    localparam logic [7:0] TLAST_C = 8'(TDIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  tcount_q;
    logic        we_q, io_q;
    logic        sync1_q, sync2_q;
    logic [15:0] address_q;
    logic [7:0]  data_out_q;
    logic        data_oe_q;
    logic        mreq_n_q, ioreq_n_q, rd_n_q, wr_n_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;

    logic        tlast_s, wait_s, limit_s, hold_s, accept_s, done_s, strobe_s, aborted_s;

`ifdef Z80_BUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);
    logic [7:0]  wait_cnt_q;
    logic        abort_q;
    logic        count_tw_s, abort_set_s;
`endif

    // Next-state decode; an I/O cycle always takes one TW after T2 before wait_n is honoured.
    always_comb begin
        tlast_s  = (tcount_q == TLAST_C);
        wait_s   = ~sync2_q;
`ifdef Z80_BUS_MASTER_TIMEOUT_EN
        limit_s   = (wait_cnt_q == WAIT_MAX_C);
        aborted_s = abort_q;
`else
        limit_s   = 1'b0;
        aborted_s = 1'b0;
`endif
        hold_s   = wait_s & ~limit_s;
        accept_s = (state_q == S_IDLE) & cmd_valid;
        done_s   = (state_q == S_T3) & tlast_s;
        state_d  = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) state_d = S_T1;
                else           state_d = S_IDLE;
            end
            S_T1: begin
                if (tlast_s) state_d = S_T2;
                else         state_d = S_T1;
            end
            S_T2: begin
                if (tlast_s) begin
                    if (io_q || hold_s) state_d = S_TW;
                    else                state_d = S_T3;
                end else begin
                    state_d = S_T2;
                end
            end
            S_TW: begin
                if (tlast_s) begin
                    if (hold_s) state_d = S_TW;
                    else        state_d = S_T3;
                end else begin
                    state_d = S_TW;
                end
            end
            S_T3: begin
                if (tlast_s) state_d = S_IDLE;
                else         state_d = S_T3;
            end
            default: state_d = S_IDLE;
        endcase
        strobe_s = (state_d == S_T2) | (state_d == S_TW) | (state_d == S_T3);
    end

`ifdef Z80_BUS_MASTER_TIMEOUT_EN
    // Timeout qualifiers: the mandatory I/O wait state is not counted.
    always_comb begin
        count_tw_s  = tlast_s & (state_d == S_TW) & ~((state_q == S_T2) & io_q);
        abort_set_s = tlast_s & wait_s & limit_s &
                      ((state_q == S_TW) | ((state_q == S_T2) & ~io_q));
    end

    // Wait-state counter and abort flag, both cleared while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            abort_q    <= 1'b0;
        end else if (state_q == S_IDLE) begin
            wait_cnt_q <= 8'd0;
            abort_q    <= 1'b0;
        end else begin
            if (count_tw_s) wait_cnt_q <= wait_cnt_q + 8'd1;
            else            wait_cnt_q <= wait_cnt_q;
            if (abort_set_s) abort_q <= 1'b1;
            else             abort_q <= abort_q;
        end
    end
`endif

    // Bus FSM state, T-state divider, wait synchronizer and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tcount_q    <= 8'd0;
            we_q        <= 1'b0;
            io_q        <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            address_q   <= 16'h0000;
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
            mreq_n_q    <= 1'b1;
            ioreq_n_q   <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= wait_n;
            sync2_q <= sync1_q;
            if ((state_q == S_IDLE) || tlast_s) tcount_q <= 8'd0;
            else                                tcount_q <= tcount_q + 8'd1;

            if (accept_s) begin
                we_q      <= cmd_we;
                io_q      <= cmd_io;
                address_q <= cmd_addr;
                data_oe_q <= cmd_we;
                if (cmd_we) data_out_q <= cmd_wdata;
                else        data_out_q <= data_out_q;
            end else if (done_s) begin
                data_oe_q <= 1'b0;
            end else begin
                data_oe_q <= data_oe_q;
            end

            mreq_n_q  <= ~(strobe_s & ~io_q);
            ioreq_n_q <= ~(strobe_s & io_q);
            rd_n_q    <= ~(strobe_s & ~we_q);
            wr_n_q    <= ~(strobe_s & we_q);

            rsp_valid_q <= done_s;
            rsp_err_q   <= done_s & aborted_s;
            if (done_s && !we_q && !aborted_s) rsp_rdata_q <= data_in;
            else                               rsp_rdata_q <= rsp_rdata_q;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) & rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign address   = address_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign mreq_n    = mreq_n_q;
    assign ioreq_n   = ioreq_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign m1_n      = 1'b1;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master at TDIV=4, WAIT_MAX=3.
module tb_z80_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic        cmd_io = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in = 8'h00;
    logic        mreq_n, ioreq_n, rd_n, wr_n, m1_n;
    logic        wait_n = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // Per-command observations
    int lat, mreq_lo, io_lo, rd_lo, wr_lo, oe_hi, seen_rsp;
    logic err_at_rsp, ready_at_rsp;

    z80_bus_master #(.TDIV(4), .WAIT_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_io(cmd_io),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .mreq_n(mreq_n), .ioreq_n(ioreq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        if (!mreq_n)  mreq_lo++;
        if (!ioreq_n) io_lo++;
        if (!rd_n)    rd_lo++;
        if (!wr_n)    wr_lo++;
        if (data_oe)  oe_hi++;
        if (rsp_valid) begin
            seen_rsp++;
            err_at_rsp   = rsp_err;
            ready_at_rsp = cmd_ready;
        end
    endtask

    // Issue one command; wait_clks > 0 holds wait_n low that many clks from T1, < 0 holds it forever.
    // lat counts posedges from the accept edge (1) through the edge that raises rsp_valid.
    task automatic run_cmd(input logic we, input logic io, input logic [15:0] addr,
                           input logic [7:0] wd, input int wait_clks, input int budget);
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_we = we; cmd_io = io; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        mreq_lo = 0; io_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0; seen_rsp = 0;
        err_at_rsp = 1'bx; ready_at_rsp = 1'bx;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 16'hFFFF; cmd_wdata = 8'hEE; cmd_we = ~we; cmd_io = ~io;
        if (wait_clks != 0) wait_n = 1'b0;
        lat = 1;
        sample();
        while (!rsp_valid && lat < budget) begin
            tick();
            lat++;
            if (wait_clks > 0 && lat == wait_clks + 1) wait_n = 1'b1;
            sample();
        end
    endtask

    initial begin
        // Reset held 3 clks
        repeat (3) tick();
        check("rst_address",   32'(address),   32'h0000);
        check("rst_data_out",  32'(data_out),  32'h00);
        check("rst_data_oe",   32'(data_oe),   32'd0);
        check("rst_strobes",   32'({mreq_n, ioreq_n, rd_n, wr_n, m1_n}), 32'h1F);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Memory read, no waits
        data_in = 8'hA5;
        run_cmd(1'b0, 1'b0, 16'h0100, 8'h00, 0, 100);
        check("mrd_latency", 32'(lat),     32'd13);
        check("mrd_mreq_lo", 32'(mreq_lo), 32'd8);
        check("mrd_rd_lo",   32'(rd_lo),   32'd8);
        check("mrd_wr_lo",   32'(wr_lo),   32'd0);
        check("mrd_io_lo",   32'(io_lo),   32'd0);
        check("mrd_oe_hi",   32'(oe_hi),   32'd0);
        check("mrd_rdata",   32'(rsp_rdata), 32'hA5);
        check("mrd_err",     32'(err_at_rsp), 32'd0);
        check("mrd_address", 32'(address), 32'h0100);
        check("mrd_ready_at_rsp", 32'(ready_at_rsp), 32'd1);

        // Memory write issued back-to-back on the rsp_valid cycle
        data_in = 8'h11;
        run_cmd(1'b1, 1'b0, 16'h9FFF, 8'h3C, 0, 100);
        check("mwr_latency", 32'(lat),     32'd13);
        check("mwr_oe_hi",   32'(oe_hi),   32'd12);
        check("mwr_wr_lo",   32'(wr_lo),   32'd8);
        check("mwr_rd_lo",   32'(rd_lo),   32'd0);
        check("mwr_mreq_lo", 32'(mreq_lo), 32'd8);
        check("mwr_data_out", 32'(data_out), 32'h3C);
        check("mwr_address", 32'(address), 32'h9FFF);
        check("mwr_rdata_held", 32'(rsp_rdata), 32'hA5);
        check("mwr_oe_end",  32'(data_oe), 32'd0);

        // Memory read with wait_n low for 10 clks from T1: two TW
        tick();
        data_in = 8'hC3;
        run_cmd(1'b0, 1'b0, 16'h2345, 8'h00, 10, 100);
        check("wait_latency", 32'(lat),     32'd21);
        check("wait_mreq_lo", 32'(mreq_lo), 32'd16);
        check("wait_rd_lo",   32'(rd_lo),   32'd16);
        check("wait_rdata",   32'(rsp_rdata), 32'hC3);
        check("wait_data_out_held", 32'(data_out), 32'h3C);
        tick();
        check("wait_rsp_pulse_1clk", 32'(rsp_valid), 32'd0);

        // I/O read: one mandatory TW
        data_in = 8'h5A;
        run_cmd(1'b0, 1'b1, 16'h00FE, 8'h00, 0, 100);
        check("io_latency", 32'(lat),     32'd17);
        check("io_ioreq_lo", 32'(io_lo),  32'd12);
        check("io_mreq_lo", 32'(mreq_lo), 32'd0);
        check("io_rd_lo",   32'(rd_lo),   32'd12);
        check("io_rdata",   32'(rsp_rdata), 32'h5A);
        check("io_m1_n",    32'(m1_n),    32'd1);

        // I/O read interrupted by reset during its TW (lat 10 is inside TW)
        tick();
        run_cmd(1'b0, 1'b1, 16'h00FE, 8'h00, 0, 10);
        check("iorst_in_tw", 32'({ioreq_n, rd_n}), 32'd0);
        rst_n = 1'b0;
        tick();
        check("iorst_strobes", 32'({mreq_n, ioreq_n, rd_n, wr_n}), 32'hF);
        check("iorst_address", 32'(address), 32'h0000);
        check("iorst_rdata",   32'(rsp_rdata), 32'h00);
        rst_n = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            sample();
        end
        check("iorst_no_rsp", 32'(seen_rsp), 32'd0);
        check("iorst_ready",  32'(cmd_ready), 32'd1);

`ifdef Z80_BUS_MASTER_TIMEOUT_EN
        // wait_n stuck low: abort after 3 TW
        data_in = 8'h77;
        run_cmd(1'b0, 1'b0, 16'h4000, 8'h00, -1, 200);
        check("to_latency", 32'(lat), 32'd25);
        check("to_err",     32'(err_at_rsp), 32'd1);
        check("to_rdata_held", 32'(rsp_rdata), 32'h00);
        check("to_mreq_lo", 32'(mreq_lo), 32'd20);
        wait_n = 1'b1;
        tick();
        check("to_err_cleared", 32'(rsp_err), 32'd0);
`else
        // wait_n stuck low: TW repeats forever
        data_in = 8'h77;
        run_cmd(1'b0, 1'b0, 16'h4000, 8'h00, -1, 1000);
        check("hang_no_rsp", 32'(seen_rsp), 32'd0);
        check("hang_mreq_low", 32'(mreq_n), 32'd0);
        check("hang_err", 32'(rsp_err), 32'd0);
        wait_n = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("hang_recover_ready", 32'(cmd_ready), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
